// File: rtl/wmem_pkg.sv
// Shared helpers for banked_wide_mem: address split and derived widths.
package wmem_pkg;

  localparam int NUM_PORTS_DEF = 2;
  localparam int NUM_BANKS_DEF = 4;
  localparam int DATA_W_DEF    = 32;
  localparam int ADDR_W_DEF    = 16;

  // Bank-select width; a single bank needs no select bits.
  function automatic int bank_bits_f(input int nb);
    return (nb > 1) ? $clog2(nb) : 0;
  endfunction

  function automatic int row_w_f(input int aw, input int nb);
    return aw - bank_bits_f(nb);
  endfunction

  function automatic int be_w_f(input int dw);
    return dw / 8;
  endfunction

  localparam int BANK_BITS = bank_bits_f(NUM_BANKS_DEF);
  localparam int ROW_W     = row_w_f(ADDR_W_DEF, NUM_BANKS_DEF);
  localparam int BE_W      = be_w_f(DATA_W_DEF);

  // Low-order interleave: bank comes from the bottom address bits.
  function automatic int bank_idx(input logic [31:0] addr, input int bb);
    logic [31:0] mask;
    mask = (32'd1 << bb) - 32'd1;
    return int'(addr & mask);
  endfunction

  function automatic logic [31:0] row_idx(input logic [31:0] addr, input int bb);
    return addr >> bb;
  endfunction

  // Per-bank request record at the default geometry.
  typedef struct packed {
    logic [2:0]            port;
    logic                  we;
    logic [ROW_W-1:0]      row;
    logic [BE_W-1:0]       be;
    logic [DATA_W_DEF-1:0] wdata;
  } bank_req_t;

endpackage

// File: rtl/banked_wide_mem_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after the pointer.
module rr_arbiter
  import wmem_pkg::*;
#(
  parameter int N = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  output logic [N-1:0] grant
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr_q, ptr_d;
  logic          found;
  int            idx;

  // One-hot grant search from the pointer, wrapping modulo N; pointer moves past the winner.
  always_comb begin
    grant = '0;
    ptr_d = ptr_q;
    found = 1'b0;
    idx   = 0;
    for (int off = 0; off < N; off++) begin
      idx = (int'(ptr_q) + off) % N;
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
        ptr_d      = PW'((idx + 1) % N);
      end
    end
  end

  // Pointer register; unchanged when nothing is granted.
  always_ff @(posedge clk) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

endmodule

// File: rtl/banked_wide_mem.sv
// Multi-port, low-order-interleaved banked word memory with per-bank RR arbitration.
module banked_wide_mem
  import wmem_pkg::*;
#(
  parameter int NUM_PORTS = 2,
  parameter int NUM_BANKS = 4,
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 16,
  parameter int READ_LAT  = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_PORTS-1:0]          req_valid,
  output logic [NUM_PORTS-1:0]          req_ready,
  input  logic [NUM_PORTS-1:0]          req_we,
  input  logic [NUM_PORTS*ADDR_W-1:0]   req_addr,
  input  logic [NUM_PORTS*DATA_W/8-1:0] req_be,
  input  logic [NUM_PORTS*DATA_W-1:0]   req_wdata,
  output logic [NUM_PORTS-1:0]          resp_valid,
  output logic [NUM_PORTS*DATA_W-1:0]   resp_rdata
);

  localparam int BB     = bank_bits_f(NUM_BANKS);
  localparam int RW     = row_w_f(ADDR_W, NUM_BANKS);
  localparam int BEW    = be_w_f(DATA_W);
  localparam int PID_W  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int BSEL_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;

  typedef struct packed {
    logic              vld;
    logic [PID_W-1:0]  port;
    logic              we;
    logic [RW-1:0]     row;
    logic [BEW-1:0]    be;
    logic [DATA_W-1:0] wdata;
  } breq_t;

  logic [NUM_BANKS-1:0][NUM_PORTS-1:0] bank_req, bank_gnt;
  logic [NUM_PORTS-1:0][BSEL_W-1:0]    port_bank;
  logic [NUM_PORTS-1:0][RW-1:0]        port_row;
  logic [NUM_BANKS-1:0][DATA_W-1:0]    bank_rdata;
  logic [NUM_PORTS-1:0]                rd_acc;

  // Split each port address into bank/row and route valid to the addressed bank; reset blocks all grants.
  always_comb begin
    bank_req  = '0;
    port_bank = '0;
    port_row  = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      port_bank[p] = BSEL_W'(bank_idx(32'(req_addr[p*ADDR_W +: ADDR_W]), BB));
      port_row[p]  = RW'(row_idx(32'(req_addr[p*ADDR_W +: ADDR_W]), BB));
      for (int b = 0; b < NUM_BANKS; b++)
        bank_req[b][p] = req_valid[p] && !rst && (int'(port_bank[p]) == b);
    end
  end

  // A port is ready when any bank granted it; reads accepted here enter the response pipe.
  always_comb begin
    req_ready = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      for (int b = 0; b < NUM_BANKS; b++)
        req_ready[p] = req_ready[p] | bank_gnt[b][p];
      rd_acc[p] = req_valid[p] && req_ready[p] && !req_we[p];
    end
  end

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    breq_t             breq;
    logic [DATA_W-1:0] mem [2**RW];
    logic [DATA_W-1:0] rdata_q, rdata_d;

    rr_arbiter #(.N(NUM_PORTS)) u_arb (
      .clk   (clk),
      .rst   (rst),
      .req   (bank_req[b]),
      .grant (bank_gnt[b])
    );

    // Mux the single granted port's request onto this bank.
    always_comb begin
      breq = '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (bank_gnt[b][p]) begin
          breq.vld   = 1'b1;
          breq.port  = PID_W'(p);
          breq.we    = req_we[p];
          breq.row   = port_row[p];
          breq.be    = req_be[p*BEW +: BEW];
          breq.wdata = req_wdata[p*DATA_W +: DATA_W];
        end
      end
    end

    // Byte-masked write; storage is deliberately never reset.
    always_ff @(posedge clk) begin
      if (breq.vld && breq.we)
        for (int i = 0; i < BEW; i++)
          if (breq.be[i]) mem[breq.row][i*8 +: 8] <= breq.wdata[i*8 +: 8];
    end

    // Read port register: captures the addressed word on a granted read.
    always_comb begin
      rdata_d = rdata_q;
      if (breq.vld && !breq.we) rdata_d = mem[breq.row];
    end

    // Holds the last word read from this bank.
    always_ff @(posedge clk) begin
      rdata_q <= rdata_d;
    end

    assign bank_rdata[b] = rdata_q;
  end

  logic [READ_LAT:1][NUM_PORTS-1:0] vld_pipe_q, vld_pipe_d;
  logic [NUM_PORTS-1:0][BSEL_W-1:0] bsel_q, bsel_d;
  logic [NUM_PORTS-1:0][DATA_W-1:0] out_q, out_d, s1_data;

  // Response pipe: stage 1 picks the bank's read register, then data holds until the next response.
  always_comb begin
    vld_pipe_d    = '0;
    vld_pipe_d[1] = rd_acc;
    for (int k = 2; k <= READ_LAT; k++) vld_pipe_d[k] = vld_pipe_q[k-1];
    for (int p = 0; p < NUM_PORTS; p++) begin
      bsel_d[p]  = rd_acc[p] ? port_bank[p] : bsel_q[p];
      s1_data[p] = vld_pipe_q[1][p] ? bank_rdata[bsel_q[p]] : out_q[p];
    end
    out_d = s1_data;
  end

  // Pipeline valids and held response data; reset drops anything in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe_q <= '0;
      bsel_q     <= '0;
      out_q      <= '0;
    end else begin
      vld_pipe_q <= vld_pipe_d;
      bsel_q     <= bsel_d;
      out_q      <= out_d;
    end
  end

  if (READ_LAT == 1) begin : g_lat1
    assign resp_valid = vld_pipe_q[1];
    assign resp_rdata = s1_data;
  end else begin : g_lat2
    assign resp_valid = vld_pipe_q[READ_LAT];
    assign resp_rdata = out_q;
  end

endmodule

// File: tb/tb_banked_wide_mem.sv
// Directed bench: drives one READ_LAT=1 and one READ_LAT=2 instance with identical stimulus.
module tb_banked_wide_mem;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid, req_we;
  logic [31:0] req_addr;
  logic [7:0]  req_be;
  logic [63:0] req_wdata;
  logic [1:0]  rdy1, rdy2, rv1, rv2;
  logic [63:0] rd1, rd2;

  int passed = 0;
  int total  = 0;
  int nresp0 = 0;
  int nresp1 = 0;

  always #5 clk = ~clk;

  banked_wide_mem #(.NUM_PORTS(2), .NUM_BANKS(4), .DATA_W(32), .ADDR_W(16), .READ_LAT(1)) u_dut1 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy1), .req_we(req_we),
    .req_addr(req_addr), .req_be(req_be), .req_wdata(req_wdata),
    .resp_valid(rv1), .resp_rdata(rd1));

  banked_wide_mem #(.NUM_PORTS(2), .NUM_BANKS(4), .DATA_W(32), .ADDR_W(16), .READ_LAT(2)) u_dut2 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy2), .req_we(req_we),
    .req_addr(req_addr), .req_be(req_be), .req_wdata(req_wdata),
    .resp_valid(rv2), .resp_rdata(rd2));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else $error("FAIL %s: got %h want %h", tag, obs, exp);
  endtask

  task automatic setp(input int p, input logic v, input logic we, input logic [15:0] a,
                      input logic [3:0] be, input logic [31:0] wd);
    req_valid[p]           = v;
    req_we[p]              = we;
    req_addr[p*16 +: 16]   = a;
    req_be[p*4 +: 4]       = be;
    req_wdata[p*32 +: 32]  = wd;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    req_valid = '0; req_we = '0; req_addr = '0; req_be = '0; req_wdata = '0;
    setp(0, 1'b1, 1'b0, 16'h0000, 4'h0, 32'h0);
    setp(1, 1'b1, 1'b0, 16'h0001, 4'h0, 32'h0);

    // reset held with both ports requesting
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_ready1", rdy1, 2'b00);
      chk("rst_ready2", rdy2, 2'b00);
      chk("rst_rv1", rv1, 2'b00);
      chk("rst_rv2", rv2, 2'b00);
    end
    chk("rst_rdata1", rd1, 64'h0);
    chk("rst_rdata2", rd2, 64'h0);

    // single-port write then read of 0x0005
    rst = 1'b0;
    setp(1, 1'b0, 1'b0, 16'h0, 4'h0, 32'h0);
    setp(0, 1'b1, 1'b1, 16'h0005, 4'hF, 32'hDEADBEEF);
    #1 chk("wr5_ready", rdy1, 2'b01);
    tick();
    setp(0, 1'b1, 1'b0, 16'h0005, 4'h0, 32'h0);
    #1 chk("rd5_ready", rdy1, 2'b01);
    tick();
    setp(0, 1'b0, 1'b0, 16'h0, 4'h0, 32'h0);
    chk("lat1_rv", rv1, 2'b01);
    chk("lat1_data", rd1[31:0], 32'hDEADBEEF);
    chk("lat2_rv_early", rv2, 2'b00);
    tick();
    chk("lat1_rv_drop", rv1, 2'b00);
    chk("lat1_data_hold", rd1[31:0], 32'hDEADBEEF);
    chk("lat2_rv", rv2, 2'b01);
    chk("lat2_data", rd2[31:0], 32'hDEADBEEF);
    tick();
    chk("lat2_rv_drop", rv2, 2'b00);

    // byte enables, plus a be=0 no-op write
    setp(0, 1'b1, 1'b1, 16'h0010, 4'hF, 32'h11223344);
    tick();
    setp(0, 1'b1, 1'b1, 16'h0010, 4'h5, 32'hAABBCCDD);
    tick();
    setp(0, 1'b1, 1'b1, 16'h0010, 4'h0, 32'hFFFFFFFF);
    tick();
    setp(0, 1'b1, 1'b0, 16'h0010, 4'h0, 32'h0);
    tick();
    setp(0, 1'b0, 1'b0, 16'h0, 4'h0, 32'h0);
    chk("be_rv", rv1, 2'b01);
    chk("be_data", rd1[31:0], 32'h11BB33DD);

    // two ports, two banks, same cycle
    setp(0, 1'b1, 1'b1, 16'h0100, 4'hF, 32'hA0A0A0A0);
    setp(1, 1'b1, 1'b1, 16'h0101, 4'hF, 32'hB1B1B1B1);
    #1 chk("par_wr_ready", rdy1, 2'b11);
    tick();
    setp(0, 1'b1, 1'b0, 16'h0100, 4'h0, 32'h0);
    setp(1, 1'b1, 1'b0, 16'h0101, 4'h0, 32'h0);
    #1 chk("par_rd_ready", rdy1, 2'b11);
    tick();
    setp(0, 1'b0, 1'b0, 16'h0, 4'h0, 32'h0);
    setp(1, 1'b0, 1'b0, 16'h0, 4'h0, 32'h0);
    chk("par_rv", rv1, 2'b11);
    chk("par_data", rd1, 64'hB1B1B1B1_A0A0A0A0);

    // fairness on bank 2: preload through port 1 so the pointer ends at 0
    setp(1, 1'b1, 1'b1, 16'h0002, 4'hF, 32'hC2C2C2C2);
    tick();
    setp(1, 1'b1, 1'b1, 16'h0006, 4'hF, 32'hC6C6C6C6);
    tick();
    setp(0, 1'b1, 1'b0, 16'h0002, 4'h0, 32'h0);
    setp(1, 1'b1, 1'b0, 16'h0006, 4'h0, 32'h0);
    for (int c = 0; c < 6; c++) begin
      #1 chk("rr_ready1", rdy1, (c % 2 == 0) ? 2'b01 : 2'b10);
      chk("rr_ready2", rdy2, (c % 2 == 0) ? 2'b01 : 2'b10);
      tick();
      chk("rr_rv", rv1, (c % 2 == 0) ? 2'b01 : 2'b10);
      if (rv1[0]) begin
        nresp0++;
        chk("rr_data0", rd1[31:0], 32'hC2C2C2C2);
      end
      if (rv1[1]) begin
        nresp1++;
        chk("rr_data1", rd1[63:32], 32'hC6C6C6C6);
      end
    end
    setp(0, 1'b0, 1'b0, 16'h0, 4'h0, 32'h0);
    setp(1, 1'b0, 1'b0, 16'h0, 4'h0, 32'h0);
    chk("rr_count0", 64'(nresp0), 64'd3);
    chk("rr_count1", 64'(nresp1), 64'd3);
    tick();

    // reset with a READ_LAT=2 read in flight
    setp(0, 1'b1, 1'b1, 16'h0020, 4'hF, 32'h5A5A5A5A);
    tick();
    setp(0, 1'b1, 1'b0, 16'h0020, 4'h0, 32'h0);
    #1 chk("mid_rd_ready", rdy2, 2'b01);
    tick();
    setp(0, 1'b0, 1'b0, 16'h0, 4'h0, 32'h0);
    rst = 1'b1;
    tick();
    chk("mid_rv2_reset", rv2, 2'b00);
    chk("mid_rd2_reset", rd2, 64'h0);
    rst = 1'b0;
    tick();
    chk("mid_rv2_after", rv2, 2'b00);

    // contents survive reset
    setp(0, 1'b1, 1'b0, 16'h0020, 4'h0, 32'h0);
    #1 chk("post_ready", rdy2, 2'b01);
    tick();
    setp(0, 1'b0, 1'b0, 16'h0, 4'h0, 32'h0);
    chk("post_rv2_early", rv2, 2'b00);
    tick();
    chk("post_rv2", rv2, 2'b01);
    chk("post_data2", rd2[31:0], 32'h5A5A5A5A);
    setp(0, 1'b1, 1'b0, 16'h0005, 4'h0, 32'h0);
    tick();
    setp(0, 1'b0, 1'b0, 16'h0, 4'h0, 32'h0);
    chk("post_rv1", rv1, 2'b01);
    chk("post_data1", rd1[31:0], 32'hDEADBEEF);
    tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
